bitcnt_unit: RTL and testbench

Multi-cycle bit-counting coprocessor attached to the EX stage, alongside the multiply/divide unit. It reuses a narrow per-chunk bit counter across several cycles instead of one full 32-bit combinational counter. It implements popcount, zero-count, count-leading-zeros and count-leading-ones. The pipeline controls it with the same start/busy convention as the multiply/divide unit and stalls while busy.

---
 rtl/bitcnt_unit_pkg.sv | 30 +++
 rtl/bitcnt_unit_if.sv | 24 ++
 rtl/bitcnt_chunk.sv | 29 ++
 rtl/bitcnt_unit.sv | 114 +++++++++++
 tb/tb_bitcnt_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/bitcnt_unit_pkg.sv
// Shared definitions for the multi-cycle bit-counting coprocessor:
// operation codes, FSM states and datapath widths.
package bitcnt_unit_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic [1:0] {
    OP_CNT1 = 2'b00,
    OP_CNT0 = 2'b01,
    OP_CLZ  = 2'b10,
    OP_CLO  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  // Zero-counting ops are turned into one-counting by inverting the operand.
  function automatic logic op_inverts(op_e op);
    return (op == OP_CNT0) || (op == OP_CLZ);
  endfunction

  function automatic logic op_leading(op_e op);
    return (op == OP_CLZ) || (op == OP_CLO);
  endfunction

endpackage

// File: rtl/bitcnt_unit_if.sv
// Start/busy handshake and result bus between the EX stage and the
// bit-counting unit.
interface bitcnt_unit_if;
  import bitcnt_unit_pkg::*;

  logic              start;
  logic [1:0]        op;
  logic [WORD_W-1:0] operand;
  logic              flush;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  result;

  modport master (
    output start, op, operand, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, operand, flush,
    output busy, done, result
  );

endinterface

// File: rtl/bitcnt_chunk.sv
// Combinational CHUNK-wide slice counter: total ones, leading ones from the
// slice MSB, and an all-ones flag used to stop leading-count accumulation.
module bitcnt_chunk
  import bitcnt_unit_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] slice_i,
  output logic [CNT_W-1:0] ones_o,
  output logic [CNT_W-1:0] lead_o,
  output logic             all_ones_o
);

  logic run;

  always_comb begin
    ones_o = '0;
    lead_o = '0;
    run    = 1'b1;
    for (int i = int'(CHUNK) - 1; i >= 0; i--) begin
      ones_o = ones_o + CNT_W'(slice_i[i]);
      run    = run & slice_i[i];
      lead_o = lead_o + CNT_W'(run);
    end
  end

  assign all_ones_o = &slice_i;

endmodule

// File: rtl/bitcnt_unit.sv
// Multi-cycle popcount / zero-count / CLZ / CLO unit. One CHUNK-wide slice is
// counted per cycle; the pipeline stalls on busy and picks up result on done.
module bitcnt_unit
  import bitcnt_unit_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input logic          clk,
  input logic          reset,
  bitcnt_unit_if.slave bus
);

  localparam int unsigned NCYC  = WORD_W / CHUNK;
  localparam int unsigned IDX_W = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int unsigned SEL_W = $clog2(WORD_W);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] data_q, data_d;
  op_e               op_q, op_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_q, stop_d;
  logic [CNT_W-1:0]  result_q, result_d;

  logic              leading;
  logic [IDX_W-1:0]  sel;
  logic [SEL_W-1:0]  base;
  logic [CHUNK-1:0]  slice;
  logic [CNT_W-1:0]  ones, lead, contrib;
  logic              all_ones;
  op_e               op_in;

  assign op_in   = op_e'(bus.op);
  assign leading = op_leading(op_q);

  // Leading counts walk slices MSB-first, plain counts LSB-first.
  assign sel   = leading ? (IDX_W'(NCYC - 1) - idx_q) : idx_q;
  assign base  = SEL_W'(32'(sel) * CHUNK);
  assign slice = data_q[base +: CHUNK];

  bitcnt_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .slice_i   (slice),
    .ones_o    (ones),
    .lead_o    (lead),
    .all_ones_o(all_ones)
  );

  assign contrib = leading ? (stop_q ? '0 : lead) : ones;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    op_d     = op_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    result_d = result_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (!bus.flush && bus.start) begin
          data_d  = op_inverts(op_in) ? ~bus.operand : bus.operand;
          op_d    = op_in;
          acc_d   = '0;
          idx_d   = '0;
          stop_d  = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          acc_d  = acc_q + contrib;
          stop_d = stop_q | (leading & ~all_ones);
          idx_d  = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NCYC - 1)) begin
            result_d = acc_q + contrib;
            state_d  = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      data_q   <= '0;
      op_q     <= OP_CNT1;
      acc_q    <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == StRun);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;

endmodule

// File: tb/tb_bitcnt_unit.sv
// Bench for bitcnt_unit: three instances (CHUNK 8, 1, 32) share one vector
// table; protocol corner cases are exercised on the CHUNK=8 instance.
module tb_bitcnt_unit;
  import bitcnt_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start_v;
  logic [1:0]  op;
  logic [31:0] operand;
  logic        flush;

  always #5 clk = ~clk;

  bitcnt_unit_if if8 ();
  bitcnt_unit_if if1 ();
  bitcnt_unit_if if32 ();

  assign if8.start    = start_v[0];
  assign if1.start    = start_v[1];
  assign if32.start   = start_v[2];
  assign if8.op       = op;
  assign if1.op       = op;
  assign if32.op      = op;
  assign if8.operand  = operand;
  assign if1.operand  = operand;
  assign if32.operand = operand;
  assign if8.flush    = flush;
  assign if1.flush    = flush;
  assign if32.flush   = flush;

  bitcnt_unit #(.CHUNK(8))  u_dut8  (.clk(clk), .reset(reset), .bus(if8.slave));
  bitcnt_unit #(.CHUNK(1))  u_dut1  (.clk(clk), .reset(reset), .bus(if1.slave));
  bitcnt_unit #(.CHUNK(32)) u_dut32 (.clk(clk), .reset(reset), .bus(if32.slave));

  logic [2:0] busy_w, done_w;
  logic [5:0] res_w [3];
  assign busy_w   = {if32.busy, if1.busy, if8.busy};
  assign done_w   = {if32.done, if1.done, if8.done};
  assign res_w[0] = if8.result;
  assign res_w[1] = if1.result;
  assign res_w[2] = if32.result;

  int ncyc [3] = '{4, 32, 1};
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] operand;
    int          exp;
    string       name;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start one op on all three instances and watch 40 cycles of handshake.
  task automatic run_vec(input vec_t v);
    int bcnt [3];
    int dcnt [3];
    int dcyc [3];
    int res  [3];
    for (int k = 0; k < 3; k++) begin
      bcnt[k] = 0; dcnt[k] = 0; dcyc[k] = -1; res[k] = -1;
    end
    op = v.op; operand = v.operand; start_v = 3'b111;
    step();
    start_v = 3'b000;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (busy_w[k]) bcnt[k]++;
        if (done_w[k]) begin
          dcnt[k]++; dcyc[k] = c; res[k] = int'(res_w[k]);
        end
      end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s/u%0d busy_cycles", v.name, ncyc[k]), bcnt[k], ncyc[k]);
      chk($sformatf("%s/u%0d done_pulses", v.name, ncyc[k]), dcnt[k], 1);
      chk($sformatf("%s/u%0d done_cycle", v.name, ncyc[k]), dcyc[k], ncyc[k]);
      chk($sformatf("%s/u%0d result", v.name, ncyc[k]), res[k], v.exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcnt, dcnt, r1, r2, d1, d2, done5, rmid, busy2;

    vecs[0]  = '{OP_CNT1, 32'hF0F0000F, 12, "cnt1_f0f0000f"};
    vecs[1]  = '{OP_CNT0, 32'h00000001, 31, "cnt0_00000001"};
    vecs[2]  = '{OP_CNT1, 32'h00000000, 0,  "cnt1_zero"};
    vecs[3]  = '{OP_CNT1, 32'hFFFFFFFF, 32, "cnt1_ones"};
    vecs[4]  = '{OP_CLZ,  32'h00010000, 15, "clz_00010000"};
    vecs[5]  = '{OP_CLZ,  32'h00000000, 32, "clz_zero"};
    vecs[6]  = '{OP_CLO,  32'hF0000000, 4,  "clo_f0000000"};
    vecs[7]  = '{OP_CLO,  32'hFF7FFFFF, 8,  "clo_ff7fffff"};
    vecs[8]  = '{OP_CNT0, 32'h00000000, 32, "cnt0_zero"};
    vecs[9]  = '{OP_CLO,  32'hFFFFFFFF, 32, "clo_ones"};
    vecs[10] = '{OP_CLZ,  32'h80000000, 0,  "clz_80000000"};
    vecs[11] = '{OP_CLZ,  32'h00000001, 31, "clz_00000001"};
    vecs[12] = '{OP_CLO,  32'h7FFFFFFF, 0,  "clo_7fffffff"};

    reset = 1'b1; start_v = 3'b000; flush = 1'b0; op = 2'b00; operand = '0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset/u%0d busy", ncyc[k]), int'(busy_w[k]), 0);
      chk($sformatf("reset/u%0d done", ncyc[k]), int'(done_w[k]), 0);
      chk($sformatf("reset/u%0d result", ncyc[k]), int'(res_w[k]), 0);
    end
    step();

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Start while busy is ignored.
    bcnt = 0; dcnt = 0; r1 = -1;
    op = OP_CNT1; operand = 32'h000000FF; start_v = 3'b001;
    step();
    start_v = 3'b000;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) begin start_v = 3'b001; operand = 32'hFFFFFFFF; end
      if (c == 2) start_v = 3'b000;
      @(negedge clk);
      if (busy_w[0]) bcnt++;
      if (done_w[0]) begin dcnt++; r1 = int'(res_w[0]); end
      step();
    end
    chk("ignore_start busy_cycles", bcnt, 4);
    chk("ignore_start done_pulses", dcnt, 1);
    chk("ignore_start result", r1, 8);

    // Back-to-back: new start accepted in the done cycle.
    bcnt = 0; dcnt = 0; r1 = -1; r2 = -1; d1 = -1; d2 = -1; done5 = -1; rmid = -1;
    op = OP_CNT1; operand = 32'h0000000F; start_v = 3'b001;
    step();
    start_v = 3'b000;
    for (int c = 0; c < 15; c++) begin
      if (c == 4) begin start_v = 3'b001; operand = 32'h000000FF; end
      if (c == 5) start_v = 3'b000;
      @(negedge clk);
      if (busy_w[0]) bcnt++;
      if (c == 5) done5 = int'(done_w[0]);
      if (c == 6) rmid = int'(res_w[0]);
      if (done_w[0]) begin
        dcnt++;
        if (dcnt == 1) begin d1 = c; r1 = int'(res_w[0]); end
        else begin d2 = c; r2 = int'(res_w[0]); end
      end
      step();
    end
    chk("b2b first_done_cycle", d1, 4);
    chk("b2b first_result", r1, 4);
    chk("b2b done_falls", done5, 0);
    chk("b2b result_held_while_busy", rmid, 4);
    chk("b2b busy_cycles", bcnt, 8);
    chk("b2b second_done_cycle", d2, 9);
    chk("b2b second_result", r2, 8);
    chk("b2b done_pulses", dcnt, 2);

    // Flush in RUN cycle 2.
    bcnt = 0; dcnt = 0; busy2 = -1;
    op = OP_CNT1; operand = 32'hFFFFFFFF; start_v = 3'b001;
    step();
    start_v = 3'b000;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) flush = 1'b1;
      if (c == 2) flush = 1'b0;
      @(negedge clk);
      if (busy_w[0]) bcnt++;
      if (done_w[0]) dcnt++;
      if (c == 2) busy2 = int'(busy_w[0]);
      step();
    end
    chk("flush busy_after", busy2, 0);
    chk("flush busy_cycles", bcnt, 2);
    chk("flush done_pulses", dcnt, 0);
    chk("flush result_kept", int'(res_w[0]), 8);

    // Flush together with start in IDLE: flush wins.
    op = OP_CNT1; operand = 32'hFFFFFFFF; start_v = 3'b001; flush = 1'b1;
    step();
    start_v = 3'b000; flush = 1'b0;
    @(negedge clk);
    chk("flush_start busy", int'(busy_w[0]), 0);
    chk("flush_start result", int'(res_w[0]), 8);
    step();

    // Reset in RUN cycle 3.
    op = OP_CNT1; operand = 32'hFFFFFFFF; start_v = 3'b001;
    step();
    start_v = 3'b000;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_reset busy", int'(busy_w[0]), 0);
    chk("mid_reset done", int'(done_w[0]), 0);
    chk("mid_reset result", int'(res_w[0]), 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
